// File: rtl/display_pkg.sv
// Shared constants and hex-to-segment table for the seven-segment display path.
// Segment encoding is active-low {dp,g,f,e,d,c,b,a}.
package display_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Hex glyphs with dp off (bit 7 high); lowercase b/d so they read as hex.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder.
// Ports: in_nib   - hex digit to show
//        in_blank - force all segments (including dp) off
//        in_dp    - light the decimal point (active-high request)
//        out_seg  - active-low segments {dp,g,f,e,d,c,b,a}
module seg7_hex_decode
  import display_pkg::*;
(
  input  logic [3:0] in_nib,
  input  logic       in_blank,
  input  logic       in_dp,
  output logic [7:0] out_seg
);

  always_comb begin
    out_seg    = hex_seg(in_nib);
    out_seg[7] = ~in_dp;
    if (in_blank) out_seg = SEG_BLANK;
  end

endmodule

// File: rtl/syscall_display_scan.sv
// Display end of the syscall print path: latches the published 32-bit value
// and scans it as 8 hex digits on a multiplexed seven-segment display. A halted
// CPU (in_lock) blinks the decimal point on digit 0.
// Ports: in_CLK/in_RST   - clock, async active-high reset
//        in_value/in_valid - value and load strobe (captured every strobe)
//        in_lock         - CPU halted level
//        out_seg         - active-low segments {dp,g,f,e,d,c,b,a}
//        out_an          - active-low one-hot digit enable
//        out_frame       - one-cycle pulse on digit wrap 7->0
module syscall_display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic [31:0] in_value,
  input  logic        in_valid,
  input  logic        in_lock,
  output logic [7:0]  out_seg,
  output logic [7:0]  out_an,
  output logic        out_frame
);

  logic [31:0] shown_q, shown_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  digit_q, digit_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_q, blink_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  an_q, an_d;
  logic        frame_q, frame_d;

  logic        adv, wrap, blank, dp;
  logic [3:0]  nib;
  logic [4:0]  sh;

  always_comb begin
    shown_d     = in_valid ? in_value : shown_q;
    adv         = (div_cnt_q == 16'(SCAN_DIV - 1));
    div_cnt_d   = adv ? 16'd0 : div_cnt_q + 16'd1;
    digit_d     = adv ? digit_q + 3'd1 : digit_q;
    wrap        = adv && (digit_q == 3'd7);
    frame_d     = wrap;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (wrap) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
    // Pins reflect the digit/value held in the registers this cycle, so any
    // state change shows up exactly one cycle later.
    an_d  = ~(8'b1 << digit_q);
    sh    = {digit_q, 2'b00};
    nib   = shown_q[sh +: 4];
    blank = (LZ_BLANK != 0) && (digit_q != 3'd0) && ((shown_q >> sh) == 32'd0);
    dp    = (digit_q == 3'd0) && in_lock && blink_q;
  end

  seg7_hex_decode u_dec (
    .in_nib  (nib),
    .in_blank(blank),
    .in_dp   (dp),
    .out_seg (seg_d)
  );

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      shown_q     <= 32'd0;
      div_cnt_q   <= 16'd0;
      digit_q     <= 3'd0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 8'hFF;
      frame_q     <= 1'b0;
    end else begin
      shown_q     <= shown_d;
      div_cnt_q   <= div_cnt_d;
      digit_q     <= digit_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign out_seg   = seg_q;
  assign out_an    = an_q;
  assign out_frame = frame_q;

endmodule

// File: tb/tb_syscall_display_scan.sv
// Bench for syscall_display_scan: four instances with different parameter sets
// share one stimulus stream; each is checked every cycle against a model that
// derives digit, frame and blink state from the cycle count since reset.
module tb_syscall_display_scan;

  localparam int N = 4;
  localparam int SD[N] = '{2, 1, 1, 4};
  localparam int BF[N] = '{2, 2, 1, 1};
  localparam int LZ[N] = '{1, 1, 0, 1};

  logic        in_CLK = 1'b0;
  logic        in_RST = 1'b1;
  logic [31:0] in_value = '0;
  logic        in_valid = 1'b0;
  logic        in_lock  = 1'b0;
  logic [7:0]  seg [N];
  logic [7:0]  an  [N];
  logic        frm [N];

  always #5 in_CLK = ~in_CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    syscall_display_scan #(.SCAN_DIV(SD[g]), .BLINK_FRAMES(BF[g]), .LZ_BLANK(LZ[g])) dut (
      .in_CLK   (in_CLK),
      .in_RST   (in_RST),
      .in_value (in_value),
      .in_valid (in_valid),
      .in_lock  (in_lock),
      .out_seg  (seg[g]),
      .out_an   (an[g]),
      .out_frame(frm[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: glyphs straight from the decode table.
  logic [7:0] HEX[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int          n;      // clock edges since reset release
  logic [31:0] shown;  // last latched value

  // Segment pins after the next edge, from the state after n edges.
  function automatic logic [7:0] m_seg(int sd, int bf, int lz, int nb, logic [31:0] v, logic lk);
    int d, blink;
    logic [7:0] s;
    d     = (nb / sd) % 8;
    blink = ((nb / (8 * sd)) / bf) % 2;
    if (lz != 0 && d != 0 && (v >> (4 * d)) == 0) return 8'hFF;
    s = HEX[v[4*d +: 4]];
    if (d == 0 && lk && blink == 1) s[7] = 1'b0;
    return s;
  endfunction

  task automatic step(input logic v, input logic [31:0] val, input logic lk);
    logic [7:0] es[N], ea[N];
    logic       ef[N];
    in_valid = v; in_value = val; in_lock = lk;
    @(posedge in_CLK);
    for (int i = 0; i < N; i++) begin
      es[i] = m_seg(SD[i], BF[i], LZ[i], n, shown, lk);
      ea[i] = ~(8'b1 << ((n / SD[i]) % 8));
      ef[i] = ((n + 1) % (8 * SD[i])) == 0;
    end
    if (v) shown = val;
    n++;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("seg%0d@%0d", i, n), {24'd0, seg[i]}, {24'd0, es[i]});
      chk($sformatf("an%0d@%0d", i, n), {24'd0, an[i]}, {24'd0, ea[i]});
      chk($sformatf("frame%0d@%0d", i, n), {31'd0, frm[i]}, {31'd0, ef[i]});
    end
    @(negedge in_CLK);
  endtask

  // Async reset in the middle of a cycle; outputs must blank at once.
  task automatic do_reset();
    #2 in_RST = 1'b1; in_valid = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_seg%0d", i), {24'd0, seg[i]}, 32'hFF);
      chk($sformatf("rst_an%0d", i), {24'd0, an[i]}, 32'hFF);
      chk($sformatf("rst_frame%0d", i), {31'd0, frm[i]}, 32'd0);
    end
    @(negedge in_CLK);
    in_RST = 1'b0;
    n = 0;
    shown = '0;
  endtask

  task automatic run(input int cyc, input logic lk);
    for (int i = 0; i < cyc; i++) step(1'b0, 32'd0, lk);
  endtask

  initial begin
    n = 0;
    shown = '0;
    @(negedge in_CLK);
    do_reset();
    run(10, 1'b0);
    do_reset();                               // mid-scan reset, full dwell after
    step(1'b1, 32'h1234ABCD, 1'b0); run(40, 1'b0);
    step(1'b1, 32'h0000000F, 1'b0); run(40, 1'b0);
    step(1'b1, 32'h00000000, 1'b0); run(40, 1'b0);
    step(1'b1, 32'h00000001, 1'b1); run(80, 1'b1);  // halt blink
    run(20, 1'b0);                            // dp drops
    step(1'b1, 32'h5, 1'b0); step(1'b1, 32'h7, 1'b0); run(20, 1'b0);
    step(1'b1, 32'h00C0FFEE, 1'b1); run(30, 1'b1);  // load while locked
    begin
      logic lk = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 31) == 0) lk = ~lk;
        if ($urandom_range(0, 599) == 0) do_reset();
        step($urandom_range(0, 3) == 0, $urandom >> $urandom_range(0, 31), lk);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
